// File: rtl/train_tx_pkg.sv
// Shared types and constants for the train_tx line transmitter.
// The EAV state exists only when TRAIN_TX_EAV_EN is defined.
package train_tx_pkg;

    localparam logic [11:0] TRAIN_WORD_DEF = 12'h719;
    localparam logic [7:0]  IDLE_BYTE_DEF  = 8'h00;

    localparam logic [11:0] EAV_WORD_A = 12'hFFF;
    localparam logic [11:0] EAV_WORD_B = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_TRAIN,
`ifdef TRAIN_TX_EAV_EN
        ST_PIX,
        ST_EAV
`else
        ST_PIX
`endif
    } state_t;

    // Byte position inside a three-byte word pair.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH0:     return PH1;
            PH1:     return PH2;
            default: return PH0;
        endcase
    endfunction

endpackage

// File: rtl/train_tx_if.sv
// Pixel handshake and byte-stream bundle for train_tx.
interface train_tx_if;

    logic        line_start;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  dout;
    logic        xhs_out;
    logic        busy;
    logic        underrun;

    modport master (
        output line_start, pix_data, pix_valid,
        input  pix_ready, dout, xhs_out, busy, underrun
    );

    modport slave (
        input  line_start, pix_data, pix_valid,
        output pix_ready, dout, xhs_out, busy, underrun
    );

endinterface

// File: rtl/train_tx_pair_packer.sv
// Packs two 12-bit words into three bytes LSB-first, one byte per clock,
// driven by the phase of the byte about to be registered.
module pair_packer
    import train_tx_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        load_en,
    input  phase_t      phase,
    input  logic [11:0] word,
    output logic [7:0]  dout
);

    logic [3:0] a_hi;
    logic [7:0] b_hi;

    // Word a arrives in phase 0, word b in phase 1; the leftovers are held.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            dout <= IDLE_BYTE;
            a_hi <= '0;
            b_hi <= '0;
        end else if (!load_en) begin
            dout <= IDLE_BYTE;
        end else begin
            case (phase)
                PH0: begin
                    dout <= word[7:0];
                    a_hi <= word[11:8];
                end
                PH1: begin
                    dout <= {word[3:0], a_hi};
                    b_hi <= word[11:4];
                end
                default: dout <= b_hi;
            endcase
        end
    end

endmodule

// File: rtl/train_tx.sv
// Line transmitter: lead filler, training words, packed pixels (and an EAV
// pair when TRAIN_TX_EAV_EN is defined) at a fixed, never-stalling rate.
module train_tx
    import train_tx_pkg::*;
#(
    parameter logic [11:0] TRAIN_WORD  = TRAIN_WORD_DEF,
    parameter int          TRAIN_PAIRS = 2,
    parameter int          PIX_PAIRS   = 256,
    parameter int          LEAD        = 2,
    parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic       clk,
    input  logic       nReset,
    train_tx_if.slave  bus
);

    localparam int LEAD_W = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam int MAXP   = (TRAIN_PAIRS > PIX_PAIRS) ? TRAIN_PAIRS : PIX_PAIRS;
    localparam int PAIR_W = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [LEAD_W-1:0] LEAD_LAST  = LEAD_W'(LEAD - 1);
    localparam logic [PAIR_W-1:0] TRAIN_LAST = PAIR_W'(TRAIN_PAIRS - 1);
    localparam logic [PAIR_W-1:0] PIX_LAST   = PAIR_W'(PIX_PAIRS - 1);

    state_t              state, state_nx;
    phase_t              phase, phase_nx;
    logic [LEAD_W-1:0]   lead_cnt, lead_cnt_nx;
    logic [PAIR_W-1:0]   pair_cnt, pair_cnt_nx;
    logic                ls_q;
    logic                seen_low;
    logic                start_edge;
    logic                load_en;
    logic                pix_take;
    logic [11:0]         word;
    logic                underrun_q;

    // seen_low keeps a line_start held high through reset from looking like an edge.
    assign start_edge = bus.line_start & ~ls_q & seen_low;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            phase    <= PH0;
            lead_cnt <= '0;
            pair_cnt <= '0;
            ls_q     <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            lead_cnt <= lead_cnt_nx;
            pair_cnt <= pair_cnt_nx;
            ls_q     <= bus.line_start;
            seen_low <= seen_low | ~bus.line_start;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        lead_cnt_nx = lead_cnt;
        pair_cnt_nx = pair_cnt;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_nx    = ST_LEAD;
                    lead_cnt_nx = '0;
                end
            end
            ST_LEAD: begin
                if (lead_cnt == LEAD_LAST) begin
                    state_nx    = ST_TRAIN;
                    phase_nx    = PH0;
                    pair_cnt_nx = '0;
                end else begin
                    lead_cnt_nx = lead_cnt + 1'b1;
                end
            end
            ST_TRAIN: begin
                if (phase != PH2) begin
                    phase_nx = next_phase(phase);
                end else if (pair_cnt == TRAIN_LAST) begin
                    state_nx    = ST_PIX;
                    phase_nx    = PH0;
                    pair_cnt_nx = '0;
                end else begin
                    phase_nx    = PH0;
                    pair_cnt_nx = pair_cnt + 1'b1;
                end
            end
            ST_PIX: begin
                if (phase != PH2) begin
                    phase_nx = next_phase(phase);
                end else if (pair_cnt == PIX_LAST) begin
`ifdef TRAIN_TX_EAV_EN
                    state_nx    = ST_EAV;
`else
                    state_nx    = ST_IDLE;
`endif
                    phase_nx    = PH0;
                    pair_cnt_nx = '0;
                end else begin
                    phase_nx    = PH0;
                    pair_cnt_nx = pair_cnt + 1'b1;
                end
            end
`ifdef TRAIN_TX_EAV_EN
            ST_EAV: begin
                if (phase != PH2) begin
                    phase_nx = next_phase(phase);
                end else begin
                    state_nx = ST_IDLE;
                    phase_nx = PH0;
                end
            end
`endif
            default: begin
                state_nx    = ST_IDLE;
                phase_nx    = PH0;
                lead_cnt_nx = '0;
                pair_cnt_nx = '0;
            end
        endcase
    end

    // Word selection looks at the upcoming state so the packer registers the right byte.
    always_comb begin
        load_en  = 1'b0;
        pix_take = 1'b0;
        word     = 12'h000;
        case (state_nx)
            ST_TRAIN: begin
                load_en = 1'b1;
                word    = TRAIN_WORD;
            end
            ST_PIX: begin
                load_en  = 1'b1;
                pix_take = (phase_nx != PH2);
                word     = (pix_take && bus.pix_valid) ? bus.pix_data : 12'h000;
            end
`ifdef TRAIN_TX_EAV_EN
            ST_EAV: begin
                load_en = 1'b1;
                word    = (phase_nx == PH0) ? EAV_WORD_A : EAV_WORD_B;
            end
`endif
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            underrun_q <= 1'b0;
        end else if (state == ST_IDLE && start_edge) begin
            underrun_q <= 1'b0;
        end else if (pix_take && !bus.pix_valid) begin
            underrun_q <= 1'b1;
        end
    end

    assign bus.pix_ready = pix_take;
    assign bus.xhs_out   = (state != ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.underrun  = underrun_q;

    pair_packer #(
        .IDLE_BYTE (IDLE_BYTE)
    ) u_packer (
        .clk     (clk),
        .nReset  (nReset),
        .load_en (load_en),
        .phase   (phase_nx),
        .word    (word),
        .dout    (bus.dout)
    );

endmodule

// File: tb/tb_train_tx.sv
// Scoreboard bench for train_tx: a line-level model pushes expected bytes,
// a monitor pops and compares them. Honours TRAIN_TX_EAV_EN.
module tb_train_tx;

    localparam int LEAD_N = 2;
    localparam int TP     = 2;
    localparam int PP     = 256;
`ifdef TRAIN_TX_EAV_EN
    localparam int EAV_N  = 3;
`else
    localparam int EAV_N  = 0;
`endif
    localparam int L        = LEAD_N + 3 * TP + 3 * PP + EAV_N;
    localparam int PIX_BASE = LEAD_N + 3 * TP;

    logic clk    = 1'b0;
    logic nReset = 1'b0;

    train_tx_if bus ();

    train_tx dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    int          len_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          exp_ur   = 1'b0;
    int          rem      = 0;
    bit          prev_ls  = 1'b0;
    bit          armed    = 1'b0;
    logic [11:0] words[2*PP];
    bit          valid[2*PP];

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushPair(input logic [11:0] a, input logic [11:0] b);
        exp_q.push_back(a[7:0]);
        exp_q.push_back({b[3:0], a[11:8]});
        exp_q.push_back(b[11:4]);
    endtask

    // Expected line, built straight from the packing rule and the pixel list.
    task automatic pushLine();
        for (int i = 0; i < LEAD_N; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < TP; i++) pushPair(12'h719, 12'h719);
        for (int j = 0; j < PP; j++)
            pushPair(valid[2*j] ? words[2*j] : 12'h000,
                     valid[2*j+1] ? words[2*j+1] : 12'h000);
`ifdef TRAIN_TX_EAV_EN
        pushPair(12'hFFF, 12'h000);
`endif
        len_q.push_back(L);
    endtask

    task automatic genWords(input int mode);
        for (int i = 0; i < 2 * PP; i++) begin
            if (mode == 2) begin
                words[i] = 12'($urandom);
                valid[i] = ($urandom_range(0, 31) != 0);
            end else begin
                words[i] = (i % 2 == 0) ? 12'h123 : 12'h456;
                valid[i] = 1'b1;
            end
        end
        if (mode == 1) valid[1] = 1'b0;
    endtask

    // One clock of stimulus; k is the byte index registered at the coming edge.
    task automatic applyStimulus(input bit ls);
        bit accepted;
        bit consume;
        int k;
        int pi;
        @(negedge clk);
        accepted = ls && !prev_ls && armed && (rem == 0);
        k        = (rem > 0) ? (L - rem + 1) : -1;
        consume  = (k >= PIX_BASE) && (k < PIX_BASE + 3 * PP) && ((k - PIX_BASE) % 3 != 2);
        pi       = consume ? (2 * ((k - PIX_BASE) / 3) + (k - PIX_BASE) % 3) : 0;
        if (accepted) begin
            pushLine();
            exp_ur = 1'b0;
        end
        bus.line_start = ls;
        if (consume) begin
            bus.pix_data  = words[pi];
            bus.pix_valid = valid[pi];
            if (!valid[pi]) exp_ur = 1'b1;
        end else begin
            bus.pix_data  = 12'($urandom);
            bus.pix_valid = 1'($urandom_range(0, 1));
        end
        #1;
        checkOutput("pix_ready", int'(bus.pix_ready), int'(consume));
        prev_ls = ls;
        if (!ls) armed = 1'b1;
        if (accepted) rem = L;
        else if (rem > 0) rem--;
    endtask

    task automatic applyReset(input bit ls, input int cycles);
        @(negedge clk);
        nReset         = 1'b0;
        bus.line_start = ls;
        exp_q.delete();
        len_q.delete();
        rem    = 0;
        exp_ur = 1'b0;
        #1;
        checkOutput("rst_dout", int'(bus.dout), 8'h00);
        checkOutput("rst_xhs", int'(bus.xhs_out), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_pix_ready", int'(bus.pix_ready), 0);
        repeat (cycles) @(negedge clk);
        nReset  = 1'b1;
        prev_ls = ls;
        armed   = !ls;
    endtask

    task automatic runLine(input int mode, input int ign_at, input int reset_at);
        genWords(mode);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        for (int c = 1; c <= L + 2; c++) begin
            if (c == reset_at) begin
                applyReset(1'b1, 3);
                return;
            end
            applyStimulus((ign_at > 0) && (c == ign_at || c == L));
        end
    endtask

    // Monitor: every cycle in a line pops one expected byte.
    int run_len = 0;
    always @(posedge clk) begin
        #2;
        if (!nReset) begin
            checkOutput("rst_dout", int'(bus.dout), 8'h00);
            checkOutput("rst_xhs", int'(bus.xhs_out), 0);
            checkOutput("rst_busy", int'(bus.busy), 0);
            checkOutput("rst_pix_ready", int'(bus.pix_ready), 0);
            checkOutput("rst_underrun", int'(bus.underrun), 0);
            run_len = 0;
        end else begin
            checkOutput("underrun", int'(bus.underrun), int'(exp_ur));
            if (bus.xhs_out) begin
                checkOutput("busy_line", int'(bus.busy), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL extra_byte actual=%0h required=none at %0t", bus.dout, $time);
                end else begin
                    checkOutput("dout", int'(bus.dout), int'(exp_q.pop_front()));
                end
                run_len++;
            end else begin
                checkOutput("busy_idle", int'(bus.busy), 0);
                checkOutput("dout_idle", int'(bus.dout), 8'h00);
                if (run_len > 0) begin
                    if (len_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL line_len actual=%0d required=no_line", run_len);
                    end else begin
                        checkOutput("line_len", run_len, len_q.pop_front());
                    end
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.line_start = 1'b0;
        bus.pix_data   = 12'h000;
        bus.pix_valid  = 1'b0;
        applyReset(1'b0, 3);
        repeat (4) applyStimulus(1'b0);

        $display("[TB] basic line");
        runLine(0, 0, 0);
        repeat (5) applyStimulus(1'b0);

        $display("[TB] underrun in pair 0");
        runLine(1, 0, 0);
        repeat (10) applyStimulus(1'b0);

        $display("[TB] ignored start edges");
        runLine(0, 100, 0);
        repeat (5) applyStimulus(1'b0);

        $display("[TB] reset mid-line");
        runLine(2, 0, 300);
        repeat (3) applyStimulus(1'b1);
        applyStimulus(1'b0);

        $display("[TB] random lines");
        runLine(2, 0, 0);
        runLine(2, 0, 0);
        repeat (5) applyStimulus(1'b0);

        checkOutput("leftover_bytes", exp_q.size(), 0);
        checkOutput("leftover_lines", len_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/train_tx.md
TRAIN_TX -- requirements
Module: train_tx

Interface
REQ-001 SHALL have parameter TRAIN_WORD, default 12'h719: 12-bit alignment word sent before pixel data.
REQ-002 SHALL have parameter TRAIN_PAIRS, default 2: number of training-word pairs per line.
REQ-003 SHALL have parameter PIX_PAIRS, default 256: pixel pairs per line (512 pixels).
REQ-004 SHALL have parameter LEAD, default 2: filler bytes between xhs_out rise and the first training byte.
REQ-005 SHALL have parameter IDLE_BYTE, default 8'h00: byte driven whenever no line is in progress.
REQ-006 SHALL have ports:
  clk  input  1  clock, all logic on rising edge.
  nReset  input  1  reset, asynchronous, active-low.
  line_start  input  1  line request; rising edge starts a line.
  pix_data  input  12  pixel word.
  pix_valid  input  1  pix_data valid.
  pix_ready  output  1  block samples pix_data at this edge.
  dout  output  8  packed byte stream, one byte per clk.
  xhs_out  output  1  line sync, high for the whole line.
  busy  output  1  line in progress.
  underrun  output  1  sticky: a pixel was needed while pix_valid was low.

Function
REQ-007 SHALL pack 12-bit words LSB-first: each word pair (a,b) becomes 3 bytes: a[7:0], then {b[3:0],a[11:8]}, then b[11:4].
REQ-008 SHALL detect the start edge as line_start high with its previous-cycle registered value low; in IDLE, the edge takes effect at that same clock edge.
REQ-009 SHALL implement states IDLE -> LEAD -> TRAIN -> PIX -> (EAV) -> IDLE; every line length is fixed and the block SHALL never stall the stream.
REQ-010 IDLE: dout=IDLE_BYTE, xhs_out=0, busy=0, pix_ready=0.
REQ-011 At the start edge: xhs_out=1 and busy=1 from that edge; LEAD cycles of IDLE_BYTE follow.
REQ-012 TRAIN SHALL emit TRAIN_PAIRS pairs of TRAIN_WORD; default bytes are 19 97 71 repeated.
REQ-013 PIX SHALL emit PIX_PAIRS pairs. pix_ready SHALL be 1 in each cycle whose edge registers phase-0 or phase-1 of a pair, and 0 otherwise.
REQ-014 At a pix_ready edge, pix_data SHALL be taken when pix_valid=1. Otherwise 12'h000 SHALL be substituted and underrun SHALL be set.
REQ-015 High nibble of a SHALL be held for phase 1, and b[11:4] held for phase 2, in internal registers.
REQ-016 After the last byte of the line, the next edge SHALL return to IDLE, with xhs_out=0 and busy=0.
REQ-017 Default line length SHALL be LEAD+3*TRAIN_PAIRS+3*PIX_PAIRS = 776 bytes.
REQ-018 A start edge while busy=1, including in the last-byte cycle, SHALL be ignored and not queued.
REQ-019 underrun SHALL stay 1 until reset or the next accepted start edge, which clears it.
REQ-020 Pair and byte counters SHALL be sized for the parameters, and SHALL clear on entering each state.

Reset
REQ-021 Reset asserted SHALL force: state IDLE, dout=IDLE_BYTE, xhs_out=0, busy=0, pix_ready=0, underrun=0, counters 0, start-edge register 0.
REQ-022 Reset mid-line SHALL abort the line immediately, with no trailing bytes.
REQ-023 After release, a start edge SHALL require line_start to be sampled low and then high.

Configuration
REQ-024 With TRAIN_TX_EAV_EN defined, one end-of-line pair (12'hFFF, 12'h000) SHALL follow PIX, giving bytes FF 0F 00 and a 779-byte default line.
REQ-025 Without TRAIN_TX_EAV_EN, PIX SHALL go directly to IDLE, and no EAV logic SHALL be present.

Structure
REQ-026 Package train_tx_pkg SHALL hold:
  the state enum;
  default TRAIN_WORD and IDLE_BYTE;
  EAV word constants;
  a phase type (0..2).
REQ-027 Sub-module pair_packer SHALL hold the phase-indexed 2-words-to-3-bytes mux and nibble holding registers; train_tx SHALL hold the FSM, counters and handshake.

Verification
REQ-028 Reset check: during and after reset, dout=00, xhs_out=0, busy=0, pix_ready=0, underrun=0.
REQ-029 Basic line: default parameters, start edge, pix_valid=1 with words 0x123,0x456 repeating. Expected: xhs_out high for 776 cycles; bytes 00 00, then 19 97 71 19 97 71, then 23 61 45 repeated 256 times; then IDLE.
REQ-030 Underrun: pix_valid=0 at the second pix_ready of pair 0. Expected: bytes 23 01 00, and underrun=1 until the next start edge.
REQ-031 Ignored start: a start edge at byte 100 and at byte 776 is ignored. Expected: exactly one 776-byte line.
REQ-032 EAV: with TRAIN_TX_EAV_EN defined, the line ends ... 45 FF 0F 00 and is 779 bytes.
REQ-033 Reset mid-line: nReset low at byte 300. Expected: dout=00 and xhs_out=0 immediately; a new start edge gives a full clean line.
